morph_ctrl: RTL and testbench
=============================

Name: morph_ctrl

Overview:
- Frame-synchronous controller for the binary morphology pipeline (erode/dilate 5x5 stages).
- Accepts operation requests over a valid/ready handshake and holds them pending.
- Applies a pending request only at a frame boundary (vsync rising edge), so a mode change never tears a frame.
- Drives the select inputs of two cascaded morphology stages and checks incoming video geometry, reporting per-frame status.

Parameters:
- H_SIZE, 64, expected active pixels per line (de-high cycles per line).
- V_SIZE, 64, expected active lines per frame.
- CNT_W, 12, width of the pixel and line counters; must satisfy 2^CNT_W > max(H_SIZE, V_SIZE).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- de  in  1  data enable of the incoming video stream
- vsync  in  1  frame sync; active-high, rising edge marks frame start
- cfg_valid  in  1  request valid
- cfg_mode  in  3  0 bypass, 1 erode, 2 dilate, 3 open, 4 close; 5-7 reserved
- cfg_ready  out  1  request can be accepted
- err_clr  in  1  single-cycle pulse; clears the sticky error flags
- stage1_sel  out  2  first-stage select: 0 bypass, 1 erode, 2 dilate
- stage2_sel  out  2  second-stage select, same encoding
- active_mode  out  3  mode currently applied
- frame_done  out  1  one-cycle pulse when a frame completes
- frame_cnt  out  16  number of completed frames
- h_err  out  1  sticky line-length mismatch flag
- v_err  out  1  sticky line-count mismatch flag

Behaviour:
- Reset: all outputs registered and reset to 0. After reset, stage selects are bypass, cfg_ready is 0 while rst is high and 1 on the first cycle after release. The pending register is cleared and the FSM goes to S_SYNC.
- Edge detection: de_d and vsync_d are registered copies of the inputs.
  - vs_rise = vsync & ~vsync_d
  - de_fall = de_d & ~de
- Handshake: a request is accepted when cfg_valid & cfg_ready. cfg_mode is then latched into pend_mode, pend_valid is set, and cfg_ready drops on the next cycle.
- Apply: on vs_rise with pend_valid=1:
  - active_mode <= pend_mode; pend_valid cleared; cfg_ready returns to 1 on the next cycle.
  - A request accepted in the same cycle as vs_rise is not applied at that boundary. It is applied at the next one.
- Select mapping, registered in the same cycle as active_mode:
  - bypass = 0/0
  - erode = 1/0
  - dilate = 2/0
  - open = 1/2
  - close = 2/1
  - Reserved codes 5-7 behave as bypass and report active_mode=0.
- FSM:
  - S_SYNC: geometry checks are disabled (partial first frame). On vs_rise: apply the pending request if any, clear the counters, go to S_RUN. No frame_done pulse is issued.
  - S_RUN: pix_cnt increments on every de=1 cycle and saturates at all-ones.
    - On de_fall: set h_err if pix_cnt != H_SIZE, increment line_cnt (saturating), clear pix_cnt.
    - On vs_rise: set v_err if line_cnt != V_SIZE, pulse frame_done for 1 cycle, increment frame_cnt (wraps at 2^16), clear the counters, apply the pending request. Stay in S_RUN.
- Simultaneous de_fall and vs_rise: the line is counted first, then the frame check uses the updated count.
- Sticky flags: err_clr clears h_err and v_err. If a set and a clear occur in the same cycle, the set wins.
- Latency:
  - Selects change 1 clk after the vs_rise cycle (vsync is sampled through vsync_d).
  - frame_done asserts in that same cycle.
- Reset mid-frame: immediate return to reset state. The pending request is discarded and the next frame is treated as partial (S_SYNC).

Decomposition:
- Package morph_pkg holds:
  - mode codes (MODE_BYPASS, MODE_ERODE, MODE_DILATE, MODE_OPEN, MODE_CLOSE)
  - stage select codes (SEL_BYPASS, SEL_ERODE, SEL_DILATE)
  - FSM state encoding
- One natural sub-module, video_geom_check: edge detectors, pix/line counters, h_err/v_err and frame_done. morph_ctrl keeps the handshake, pending register, FSM and select mapping.

Test Plan:
- Reset release, no stimulus -> stage1_sel=0, stage2_sel=0, frame_cnt=0, cfg_ready=1 from the first post-reset cycle.
- Request mode 3 mid-frame -> cfg_ready=0 until the next vs_rise. Then stage1_sel=1, stage2_sel=2, active_mode=3, and cfg_ready=1 one cycle later.
- Two frames of 64 lines x 64 pixels -> frame_done pulses once per frame, frame_cnt=2, h_err=0, v_err=0. The first (partial) frame is not counted.
- One line of 63 pixels and a frame of 65 lines -> h_err=1 and v_err=1. Both stay set until err_clr; err_clr coinciding with a new error leaves the flag set.
- Request mode 4 accepted in the exact vs_rise cycle -> the current frame keeps the old mode, and 2/1 is applied at the following vs_rise.
- Request mode 6, then rst asserted mid-frame while a request is pending -> mode 6 yields bypass. After the reset, selects are 0, the pending request is dropped and no frame_done is issued on the first vs_rise.

Source files
------------

// File: rtl/morph_pkg.sv
// Shared definitions for the morphology pipeline controller: mode codes,
// per-stage select codes, controller state encoding and the mode decoders.
package morph_pkg;

    typedef enum logic [2:0] {
        MODE_BYPASS = 3'd0,
        MODE_ERODE  = 3'd1,
        MODE_DILATE = 3'd2,
        MODE_OPEN   = 3'd3,
        MODE_CLOSE  = 3'd4
    } mode_e;

    typedef enum logic [1:0] {
        SEL_BYPASS = 2'd0,
        SEL_ERODE  = 2'd1,
        SEL_DILATE = 2'd2
    } sel_e;

    typedef enum logic {
        S_SYNC = 1'b0,
        S_RUN  = 1'b1
    } state_e;

    typedef struct packed {
        sel_e s1;
        sel_e s2;
    } sel_pair_t;

    // Reserved codes collapse to bypass so the reported mode matches the selects.
    function automatic logic [2:0] mode_norm(input logic [2:0] mode);
        logic [2:0] m;
        case (mode)
            MODE_BYPASS, MODE_ERODE, MODE_DILATE,
            MODE_OPEN, MODE_CLOSE: m = mode;
            default:               m = MODE_BYPASS;
        endcase
        return m;
    endfunction

    // Open is erode-then-dilate, close is dilate-then-erode.
    function automatic sel_pair_t mode_to_sel(input logic [2:0] mode);
        sel_pair_t sp;
        case (mode)
            MODE_ERODE:  begin sp.s1 = SEL_ERODE;  sp.s2 = SEL_BYPASS; end
            MODE_DILATE: begin sp.s1 = SEL_DILATE; sp.s2 = SEL_BYPASS; end
            MODE_OPEN:   begin sp.s1 = SEL_ERODE;  sp.s2 = SEL_DILATE; end
            MODE_CLOSE:  begin sp.s1 = SEL_DILATE; sp.s2 = SEL_ERODE;  end
            default:     begin sp.s1 = SEL_BYPASS; sp.s2 = SEL_BYPASS; end
        endcase
        return sp;
    endfunction

endpackage

// File: rtl/morph_ctrl_video_geom_check.sv
// Video geometry checker: detects vsync/de edges, counts pixels per line and
// lines per frame, raises sticky h_err/v_err and counts completed frames.
module video_geom_check #(
    parameter int H_SIZE = 64,
    parameter int V_SIZE = 64,
    parameter int CNT_W  = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        de,
    input  logic        vsync,
    input  logic        run,
    input  logic        err_clr,
    output logic        vs_rise,
    output logic        frame_done,
    output logic [15:0] frame_cnt,
    output logic        h_err,
    output logic        v_err
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] H_EXP   = CNT_W'(H_SIZE);
    localparam logic [CNT_W-1:0] V_EXP   = CNT_W'(V_SIZE);

    logic             de_d;
    logic             vsync_d;
    logic             de_fall;
    logic [CNT_W-1:0] pix_cnt;
    logic [CNT_W-1:0] line_cnt;
    logic [CNT_W-1:0] line_upd;
    logic             h_set;
    logic             v_set;

    // Edge detection and error-set decisions; a line ending together with
    // vsync is counted before the frame length is judged.
    always_comb begin
        vs_rise = vsync & ~vsync_d;
        de_fall = de_d & ~de;
        if (de_fall) begin
            line_upd = (line_cnt == CNT_MAX) ? line_cnt : line_cnt + CNT_ONE;
        end else begin
            line_upd = line_cnt;
        end
        h_set = run & de_fall & (pix_cnt != H_EXP);
        v_set = run & vs_rise & (line_upd != V_EXP);
    end

    // Input delay taps, saturating counters, frame counter and sticky flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            de_d       <= 1'b0;
            vsync_d    <= 1'b0;
            pix_cnt    <= '0;
            line_cnt   <= '0;
            frame_done <= 1'b0;
            frame_cnt  <= 16'd0;
            h_err      <= 1'b0;
            v_err      <= 1'b0;
        end else begin
            de_d       <= de;
            vsync_d    <= vsync;
            frame_done <= run & vs_rise;
            if (run & vs_rise) begin
                frame_cnt <= frame_cnt + 16'd1;
            end else begin
                frame_cnt <= frame_cnt;
            end
            if (!run || vs_rise) begin
                pix_cnt  <= '0;
                line_cnt <= '0;
            end else if (de_fall) begin
                pix_cnt  <= '0;
                line_cnt <= line_upd;
            end else if (de && (pix_cnt != CNT_MAX)) begin
                pix_cnt  <= pix_cnt + CNT_ONE;
            end else begin
                pix_cnt  <= pix_cnt;
            end
            // A new error in the same cycle as a clear must survive.
            if (h_set) begin
                h_err <= 1'b1;
            end else if (err_clr) begin
                h_err <= 1'b0;
            end else begin
                h_err <= h_err;
            end
            if (v_set) begin
                v_err <= 1'b1;
            end else if (err_clr) begin
                v_err <= 1'b0;
            end else begin
                v_err <= v_err;
            end
        end
    end

endmodule

// File: rtl/morph_ctrl.sv
// Frame-synchronous controller for the cascaded erode/dilate stages: accepts a
// mode request, holds it pending and applies it only at a vsync rising edge.
module morph_ctrl
    import morph_pkg::*;
#(
    parameter int H_SIZE = 64,
    parameter int V_SIZE = 64,
    parameter int CNT_W  = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        de,
    input  logic        vsync,
    input  logic        cfg_valid,
    input  logic [2:0]  cfg_mode,
    output logic        cfg_ready,
    input  logic        err_clr,
    output logic [1:0]  stage1_sel,
    output logic [1:0]  stage2_sel,
    output logic [2:0]  active_mode,
    output logic        frame_done,
    output logic [15:0] frame_cnt,
    output logic        h_err,
    output logic        v_err
);

    state_e     state;
    logic       run;
    logic       vs_rise;
    logic       accept;
    logic       pend_valid;
    logic [2:0] pend_mode;
    logic [2:0] mode_nxt;
    sel_pair_t  sel_nxt;

    // Handshake qualifier and decode of the pending request.
    always_comb begin
        run      = (state == S_RUN);
        accept   = cfg_valid & cfg_ready;
        mode_nxt = mode_norm(pend_mode);
        sel_nxt  = mode_to_sel(pend_mode);
    end

    video_geom_check #(
        .H_SIZE (H_SIZE),
        .V_SIZE (V_SIZE),
        .CNT_W  (CNT_W)
    ) u_geom (
        .clk        (clk),
        .rst        (rst),
        .de         (de),
        .vsync      (vsync),
        .run        (run),
        .err_clr    (err_clr),
        .vs_rise    (vs_rise),
        .frame_done (frame_done),
        .frame_cnt  (frame_cnt),
        .h_err      (h_err),
        .v_err      (v_err)
    );

    // Controller state, pending request and registered stage selects.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_SYNC;
            pend_valid  <= 1'b0;
            pend_mode   <= 3'd0;
            cfg_ready   <= 1'b0;
            active_mode <= 3'd0;
            stage1_sel  <= 2'd0;
            stage2_sel  <= 2'd0;
        end else begin
            case (state)
                S_SYNC:  state <= vs_rise ? S_RUN : S_SYNC;
                S_RUN:   state <= S_RUN;
                default: state <= S_SYNC;
            endcase
            // A request can only be accepted while nothing is pending, so apply
            // and accept never compete; a request taken on the vsync edge
            // itself waits for the next frame.
            if (vs_rise && pend_valid) begin
                active_mode <= mode_nxt;
                stage1_sel  <= sel_nxt.s1;
                stage2_sel  <= sel_nxt.s2;
                pend_valid  <= 1'b0;
                cfg_ready   <= 1'b1;
            end else if (accept) begin
                pend_mode   <= cfg_mode;
                pend_valid  <= 1'b1;
                cfg_ready   <= 1'b0;
            end else begin
                cfg_ready   <= ~pend_valid;
            end
        end
    end

endmodule

// File: tb/tb_morph_ctrl.sv
// Self-checking bench for morph_ctrl: a frame-level reference model compared
// against the DUT on every cycle, plus hand-computed checkpoints.
module tb_morph_ctrl;

    logic        clk;
    logic        rst;
    logic        de;
    logic        vsync;
    logic        cfg_valid;
    logic [2:0]  cfg_mode;
    logic        cfg_ready;
    logic        err_clr;
    logic [1:0]  stage1_sel;
    logic [1:0]  stage2_sel;
    logic [2:0]  active_mode;
    logic        frame_done;
    logic [15:0] frame_cnt;
    logic        h_err;
    logic        v_err;

    int total = 0;
    int bad   = 0;
    int done_seen = 0;

    morph_ctrl #(.H_SIZE(64), .V_SIZE(64), .CNT_W(12)) dut (
        .clk(clk), .rst(rst), .de(de), .vsync(vsync),
        .cfg_valid(cfg_valid), .cfg_mode(cfg_mode), .cfg_ready(cfg_ready),
        .err_clr(err_clr), .stage1_sel(stage1_sel), .stage2_sel(stage2_sel),
        .active_mode(active_mode), .frame_done(frame_done), .frame_cnt(frame_cnt),
        .h_err(h_err), .v_err(v_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 40) $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int sel1_tab [8] = '{0, 1, 2, 1, 2, 0, 0, 0};
    int sel2_tab [8] = '{0, 0, 0, 2, 1, 0, 0, 0};
    int m_pix, m_lines, m_frames, m_pmode, m_active;
    bit m_done, m_herr, m_verr, m_ready, m_pend, m_synced;
    bit m_prev_vs, m_prev_de, m_live;
    bit vr, df, hset, vset;

    initial begin
        m_live = 1'b0;
        forever begin
            @(posedge clk);
            if (rst) begin
                m_pix = 0; m_lines = 0; m_frames = 0; m_pmode = 0; m_active = 0;
                m_done = 0; m_herr = 0; m_verr = 0; m_ready = 0; m_pend = 0;
                m_synced = 0; m_prev_vs = 0; m_prev_de = 0; m_live = 1;
            end else begin
                vr = vsync && !m_prev_vs;
                df = m_prev_de && !de;
                hset = 0; vset = 0; m_done = 0;
                if (m_synced) begin
                    if (df) begin
                        hset    = (m_pix != 64);
                        m_lines = (m_lines < 4095) ? m_lines + 1 : 4095;
                        m_pix   = 0;
                    end else if (de) begin
                        m_pix = (m_pix < 4095) ? m_pix + 1 : 4095;
                    end
                    if (vr) begin
                        vset     = (m_lines != 64);
                        m_done   = 1;
                        m_frames = (m_frames + 1) % 65536;
                        m_pix    = 0;
                        m_lines  = 0;
                    end
                end else if (vr) begin
                    m_synced = 1;
                end
                m_herr = hset | (m_herr & !err_clr);
                m_verr = vset | (m_verr & !err_clr);
                if (vr && m_pend) begin
                    m_active = (m_pmode <= 4) ? m_pmode : 0;
                    m_pend   = 0;
                end else if (cfg_valid && m_ready) begin
                    m_pend  = 1;
                    m_pmode = int'(cfg_mode);
                end
                m_ready   = !m_pend;
                m_prev_vs = vsync;
                m_prev_de = de;
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (m_live) begin
                chk("cfg_ready",   32'(cfg_ready),   32'(m_ready));
                chk("active_mode", 32'(active_mode), 32'(m_active));
                chk("stage1_sel",  32'(stage1_sel),  32'(sel1_tab[m_active]));
                chk("stage2_sel",  32'(stage2_sel),  32'(sel2_tab[m_active]));
                chk("frame_done",  32'(frame_done),  32'(m_done));
                chk("frame_cnt",   32'(frame_cnt),   32'(m_frames));
                chk("h_err",       32'(h_err),       32'(m_herr));
                chk("v_err",       32'(v_err),       32'(m_verr));
            end
        end
    end

    // Count frame_done pulses since the last reset.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) done_seen = 0;
            else if (frame_done === 1'b1) done_seen++;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic line(input int len, input bit clr);
        de = 1'b1;
        repeat (len) cyc();
        de = 1'b0;
        err_clr = clr;
        cyc();
        err_clr = 1'b0;
        repeat (3) cyc();
    endtask

    task automatic body(input int n, input int short_idx);
        for (int i = 0; i < n; i++) line((i == short_idx) ? 63 : 64, 1'b0);
    endtask

    task automatic vpulse();
        vsync = 1'b1;
        repeat (2) cyc();
        vsync = 1'b0;
        repeat (2) cyc();
    endtask

    task automatic req(input logic [2:0] m);
        chk("req_ready", 32'(cfg_ready), 32'd1);
        cfg_valid = 1'b1;
        cfg_mode  = m;
        cyc();
        cfg_valid = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst = 1'b1; de = 1'b0; vsync = 1'b0;
        cfg_valid = 1'b0; cfg_mode = 3'd0; err_clr = 1'b0;
        repeat (3) cyc();
        chk("ready_in_reset", 32'(cfg_ready), 32'd0);
        rst = 1'b0;
        cyc();
        chk("post_rst_ready", 32'(cfg_ready),  32'd1);
        chk("post_rst_sel1",  32'(stage1_sel), 32'd0);
        chk("post_rst_sel2",  32'(stage2_sel), 32'd0);
        chk("post_rst_fcnt",  32'(frame_cnt),  32'd0);

        // Partial frame with an open request pending.
        body(4, -1);
        req(3'd3);
        chk("ready_drops", 32'(cfg_ready), 32'd0);
        body(4, -1);
        chk("ready_held", 32'(cfg_ready), 32'd0);
        chk("mode_held",  32'(active_mode), 32'd0);
        vsync = 1'b1;
        cyc();
        chk("open_mode",  32'(active_mode), 32'd3);
        chk("open_sel1",  32'(stage1_sel),  32'd1);
        chk("open_sel2",  32'(stage2_sel),  32'd2);
        chk("open_ready", 32'(cfg_ready),   32'd1);
        chk("sync_no_done", 32'(frame_done), 32'd0);
        cyc();
        vsync = 1'b0;
        repeat (2) cyc();

        // Two clean 64x64 frames.
        body(64, -1);
        vpulse();
        body(64, -1);
        vpulse();
        chk("two_frames_cnt",  32'(frame_cnt), 32'd2);
        chk("two_frames_done", 32'(done_seen), 32'd2);
        chk("clean_h_err",     32'(h_err),     32'd0);
        chk("clean_v_err",     32'(v_err),     32'd0);

        // 65 lines with one 63-pixel line.
        body(65, 5);
        vpulse();
        chk("err_h", 32'(h_err), 32'd1);
        chk("err_v", 32'(v_err), 32'd1);
        chk("err_fcnt", 32'(frame_cnt), 32'd3);
        line(63, 1'b1);
        chk("clr_vs_set_h", 32'(h_err), 32'd1);
        chk("clr_v",        32'(v_err), 32'd0);
        err_clr = 1'b1;
        cyc();
        err_clr = 1'b0;
        chk("clr_h", 32'(h_err), 32'd0);
        body(63, -1);
        vpulse();
        chk("after_clr_h", 32'(h_err), 32'd0);
        chk("after_clr_v", 32'(v_err), 32'd0);
        chk("after_clr_fcnt", 32'(frame_cnt), 32'd4);

        // Close request accepted on the vsync edge itself.
        body(64, -1);
        vsync = 1'b1; cfg_valid = 1'b1; cfg_mode = 3'd4;
        cyc();
        cfg_valid = 1'b0;
        chk("edge_req_mode",  32'(active_mode), 32'd3);
        chk("edge_req_sel1",  32'(stage1_sel),  32'd1);
        chk("edge_req_ready", 32'(cfg_ready),   32'd0);
        chk("edge_done",      32'(frame_done),  32'd1);
        chk("edge_fcnt",      32'(frame_cnt),   32'd5);
        cyc();
        vsync = 1'b0;
        repeat (2) cyc();
        body(64, -1);
        vsync = 1'b1;
        cyc();
        chk("close_mode", 32'(active_mode), 32'd4);
        chk("close_sel1", 32'(stage1_sel),  32'd2);
        chk("close_sel2", 32'(stage2_sel),  32'd1);
        chk("close_fcnt", 32'(frame_cnt),   32'd6);
        cyc();
        vsync = 1'b0;
        repeat (2) cyc();

        // Reserved mode 6 collapses to bypass.
        body(10, -1);
        req(3'd6);
        body(5, -1);
        vpulse();
        chk("rsvd_mode", 32'(active_mode), 32'd0);
        chk("rsvd_sel1", 32'(stage1_sel),  32'd0);
        chk("rsvd_sel2", 32'(stage2_sel),  32'd0);

        // Reset mid-frame with a dilate request pending.
        body(3, -1);
        req(3'd2);
        body(2, -1);
        chk("pend_before_rst", 32'(cfg_ready), 32'd0);
        rst = 1'b1;
        repeat (2) cyc();
        rst = 1'b0;
        cyc();
        chk("rst2_ready", 32'(cfg_ready),   32'd1);
        chk("rst2_mode",  32'(active_mode), 32'd0);
        chk("rst2_fcnt",  32'(frame_cnt),   32'd0);
        chk("rst2_h_err", 32'(h_err),       32'd0);
        body(3, -1);
        vpulse();
        chk("rst2_no_done", 32'(done_seen),   32'd0);
        chk("rst2_dropped", 32'(active_mode), 32'd0);
        chk("rst2_sel1",    32'(stage1_sel),  32'd0);
        body(2, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
